// File: rtl/placement_pkg.sv
// Shared types and defaults for the annealing placer position-swap path.
package placement_pkg;

    localparam int unsigned N_NODE_DEF = 14;
    localparam int unsigned POS_DW     = 32;
    localparam int unsigned IDX_AW     = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StWrA,
        StWrB,
        StFin
    } swap_state_e;

endpackage

// File: rtl/pos_swap_ctrl.sv
// Swap engine: reads (x,y) of two nodes from the pos_X/pos_Y memories and writes them back
// exchanged. Optional macro SWAP_BOUNDS_CHECK_EN rejects out-of-range indices with err.
module pos_swap_ctrl
    import placement_pkg::*;
#(
    parameter int unsigned N_NODE = N_NODE_DEF,
    parameter int unsigned DW     = POS_DW,
    parameter int unsigned AW     = IDX_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] node_a,
    input  logic [AW-1:0] node_b,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata_x,
    output logic [DW-1:0] mem_wdata_y,
    input  logic [DW-1:0] mem_rdata_x,
    input  logic [DW-1:0] mem_rdata_y
);

    swap_state_e   state_q, state_d;
    logic [AW-1:0] idx_a_q, idx_b_q;
    logic [DW-1:0] tmp_x_q, tmp_y_q;
    logic          reject;

`ifdef SWAP_BOUNDS_CHECK_EN
    logic err_q;
    assign reject = (node_a >= AW'(N_NODE)) || (node_b >= AW'(N_NODE));
`else
    assign reject = 1'b0;
`endif

    // State, captured indices and A's data held across the write phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_a_q <= '0;
            idx_b_q <= '0;
            tmp_x_q <= '0;
            tmp_y_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                idx_a_q <= node_a;
                idx_b_q <= node_b;
            end
            // A's data arrives from the memory while we issue B's read
            if (state_q == StRdB) begin
                tmp_x_q <= mem_rdata_x;
                tmp_y_q <= mem_rdata_y;
            end
        end
    end

`ifdef SWAP_BOUNDS_CHECK_EN
    // Remember whether the accepted request was rejected, reported during FIN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            err_q <= reject;
        end
    end
    assign err = (state_q == StFin) && err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state sequencing; self-swap and rejected requests skip all memory traffic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (reject || node_a == node_b) state_d = StFin;
                    else                            state_d = StRdA;
                end
            end
            StRdA:   state_d = StRdB;
            StRdB:   state_d = StWrA;
            StWrA:   state_d = StWrB;
            StWrB:   state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory control and status decoded from the state register only
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata_x = '0;
        mem_wdata_y = '0;
        unique case (state_q)
            StRdA: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = idx_a_q;
            end
            StRdB: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = idx_b_q;
            end
            StWrA: begin
                // B's data is on the read port this cycle; pass it straight through
                busy        = 1'b1;
                mem_write   = 1'b1;
                mem_addr    = idx_a_q;
                mem_wdata_x = mem_rdata_x;
                mem_wdata_y = mem_rdata_y;
            end
            StWrB: begin
                busy        = 1'b1;
                mem_write   = 1'b1;
                mem_addr    = idx_b_q;
                mem_wdata_x = tmp_x_q;
                mem_wdata_y = tmp_y_q;
            end
            StFin:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pos_swap_ctrl.sv
// Directed bench for pos_swap_ctrl with two behavioural sync position memories.
module tb_pos_swap_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] node_a, node_b;
    logic        busy, done, err, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata_x, mem_wdata_y;
    logic [31:0] mem_rdata_x, mem_rdata_y;

    logic [31:0] mx [16];
    logic [31:0] my [16];
    logic        reload;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    pos_swap_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .node_a     (node_a),
        .node_b     (node_b),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata_x(mem_wdata_x),
        .mem_wdata_y(mem_wdata_y),
        .mem_rdata_x(mem_rdata_x),
        .mem_rdata_y(mem_rdata_y)
    );

    // Sync memories: 1-cycle read, write only when not reading; reload restores x=i, y=16+i
    always @(posedge clk) begin
        if (reload) begin
            for (int i = 0; i < 16; i++) begin
                mx[i] <= 32'(i);
                my[i] <= 32'(16 + i);
            end
        end else if (mem_read) begin
            if (mem_addr < 16) begin
                mem_rdata_x <= mx[mem_addr[3:0]];
                mem_rdata_y <= my[mem_addr[3:0]];
            end
        end else if (mem_write && mem_addr < 16) begin
            mx[mem_addr[3:0]] <= mem_wdata_x;
            my[mem_addr[3:0]] <= mem_wdata_y;
        end
    end

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (done)      done_cnt++;
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
        if (err)       err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reload();
        @(negedge clk) reload = 1'b1;
        @(negedge clk) reload = 1'b0;
    endtask

    // Present a request for one cycle; returns just after the accepting edge
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        node_a = a;
        node_b = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        node_a = 32'hdead_beef;
        node_b = 32'hdead_beef;
    endtask

    // Edges after acceptance until done is seen; then step past FIN into IDLE
    task automatic wait_done(input string tag, input int exp_edges);
        int n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(n), 32'(exp_edges));
        @(posedge clk);
        #1;
    endtask

    // Entries differing from the preload, excluding up to two swapped indices
    function automatic int count_dirty(input int skip0, input int skip1);
        int c = 0;
        for (int i = 0; i < 16; i++) begin
            if (i != skip0 && i != skip1 && (mx[i] != 32'(i) || my[i] != 32'(16 + i))) c++;
        end
        return c;
    endfunction

    int rd0, wr0, dn0, er0;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        reload  = 1'b0;
        node_a  = '0;
        node_b  = '0;
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_rd", 32'(mem_read), 0);
        check_eq("rst_wr", 32'(mem_write), 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdx", mem_wdata_x, 0);
        check_eq("rst_wdy", mem_wdata_y, 0);
        do_reload();
        @(negedge clk) reset_n = 1'b1;

        // T1: plain swap 2<->9; RD_A,RD_B,WR_A,WR_B then FIN at the 4th edge
        do_start(32'd2, 32'd9);
        check_eq("t1_busy", 32'(busy), 1);
        check_eq("t1_rd_addr", mem_addr, 2);
        wait_done("t1_latency", 4);
        check_eq("t1_x2", mx[2], 9);
        check_eq("t1_y2", my[2], 25);
        check_eq("t1_x9", mx[9], 2);
        check_eq("t1_y9", my[9], 18);
        check_eq("t1_others", 32'(count_dirty(2, 9)), 0);
        check_eq("t1_idle_busy", 32'(busy), 0);

        // T2: self-swap goes straight to FIN with no memory traffic
        do_reload();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_start(32'd5, 32'd5);
        wait_done("t2_latency", 0);
        check_eq("t2_reads", 32'(rd_cnt - rd0), 0);
        check_eq("t2_writes", 32'(wr_cnt - wr0), 0);
        check_eq("t2_mem", 32'(count_dirty(-1, -1)), 0);

        // T3: second request while busy is dropped
        dn0 = done_cnt;
        do_start(32'd1, 32'd3);
        @(negedge clk);
        node_a = 32'd4;
        node_b = 32'd6;
        start  = 1'b1;
        repeat (2) @(negedge clk);
        start  = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t3_done_pulses", 32'(done_cnt - dn0), 1);
        check_eq("t3_x1", mx[1], 3);
        check_eq("t3_x3", mx[3], 1);
        check_eq("t3_y1", my[1], 19);
        check_eq("t3_others", 32'(count_dirty(1, 3)), 0);

        // T4: async reset during RD_B aborts with memories untouched
        do_reload();
        do_start(32'd2, 32'd9);
        @(posedge clk);
        #3;
        check_eq("t4_in_rdb_addr", mem_addr, 9);
        reset_n = 1'b0;
        #1;
        check_eq("t4_busy", 32'(busy), 0);
        check_eq("t4_rd", 32'(mem_read), 0);
        check_eq("t4_wr", 32'(mem_write), 0);
        check_eq("t4_addr", mem_addr, 0);
        check_eq("t4_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        check_eq("t4_mem", 32'(count_dirty(-1, -1)), 0);
        reset_n = 1'b1;
        do_start(32'd0, 32'd1);
        wait_done("t4_post_latency", 4);
        check_eq("t4_post_x0", mx[0], 1);
        check_eq("t4_post_x1", mx[1], 0);

        // T5: out-of-range index
        do_reload();
        er0 = err_cnt;
`ifdef SWAP_BOUNDS_CHECK_EN
        do_start(32'd14, 32'd0);
        check_eq("t5_err", 32'(err), 1);
        check_eq("t5_done", 32'(done), 1);
        wait_done("t5_latency", 0);
        check_eq("t5_mem", 32'(count_dirty(-1, -1)), 0);
        check_eq("t5_err_pulses", 32'(err_cnt - er0), 1);
`else
        do_start(32'd14, 32'd0);
        wait_done("t5_latency", 4);
        check_eq("t5_err_pulses", 32'(err_cnt - er0), 0);
        check_eq("t5_x14", mx[14], 0);
        check_eq("t5_x0", mx[0], 14);
`endif

        // T6: back-to-back swaps, second issued in the IDLE cycle after FIN
        do_reload();
        do_start(32'd0, 32'd1);
        wait_done("t6a_latency", 4);
        do_start(32'd1, 32'd2);
        wait_done("t6b_latency", 4);
        check_eq("t6_x0", mx[0], 1);
        check_eq("t6_x1", mx[1], 2);
        check_eq("t6_x2", mx[2], 0);
        check_eq("t6_y0", my[0], 17);
        check_eq("t6_y1", my[1], 18);
        check_eq("t6_y2", my[2], 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
